// File: rtl/frame_pkg.sv
// Shared constants for the frame sweep controller: FSM encoding, default widths
// and the legal datapath-latency range.
package frame_pkg;

  localparam int DIM_W_DEF    = 9;
  localparam int ADDR_W_DEF   = 17;
  localparam int PIPE_LAT_MIN = 1;
  localparam int PIPE_LAT_MAX = 15;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/sweep_delay_pipe.sv
// {valid, addr} shift register that tracks issued pixels through the datapath
// latency; advances on enable, clears valids on synchronous flush.
module sweep_delay_pipe #(
  parameter int ADDR_W = 17,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              will_empty
);

  logic [LAT-1:0]    valid;
  logic [ADDR_W-1:0] addr [LAT];

  // Stage registers: flush drops all valids, advance shifts one stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < LAT; i++) begin
        addr[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (advance) begin
      valid[0] <= in_valid;
      addr[0]  <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        valid[i] <= valid[i-1];
        addr[i]  <= addr[i-1];
      end
    end
  end

  // True when the coming edge leaves every stage invalid (last stage retires now)
  always_comb begin
    will_empty = advance & ~in_valid;
    for (int i = 0; i < LAT - 1; i++) begin
      will_empty = will_empty & ~valid[i];
    end
  end

  assign out_valid = valid[LAT-1];
  assign out_addr  = addr[LAT-1];

endmodule

// File: rtl/frame_sweep_controller.sv
// Raster-sweep controller: issues one pixel per cycle, tracks write-back through
// a PIPE_LAT pipe and pulses done. Optional busy-cycle counter: FRAME_SWEEP_PERF_EN.
module frame_sweep_controller
  import frame_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DIM_W    = DIM_W_DEF,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DIM_W-1:0]  rd_x,
  output logic [DIM_W-1:0]  rd_y,
  output logic              wren,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done,
  output logic [31:0]       cycle_count
);

  // Out-of-range latencies are pulled into the supported window
  localparam int LAT = (PIPE_LAT < PIPE_LAT_MIN) ? PIPE_LAT_MIN :
                       (PIPE_LAT > PIPE_LAT_MAX) ? PIPE_LAT_MAX : PIPE_LAT;

  state_t            state;
  state_t            state_nxt;
  logic [DIM_W-1:0]  width_lat;
  logic [DIM_W-1:0]  height_lat;
  logic [DIM_W-1:0]  x;
  logic [DIM_W-1:0]  y;
  logic [ADDR_W-1:0] addr;
  logic              dims_ok;
  logic              row_end;
  logic              last_pix;
  logic              pipe_valid;
  logic              will_empty;

  assign dims_ok  = (cfg_width != '0) && (cfg_height != '0);
  assign row_end  = (x == width_lat - DIM_W'(1));
  assign last_pix = row_end && (y == height_lat - DIM_W'(1));

  assign busy    = (state != ST_IDLE);
  assign rd_en   = (state == ST_RUN) && !stall;
  assign rd_addr = addr;
  assign rd_x    = x;
  assign rd_y    = y;
  assign wren    = pipe_valid && !stall;
  assign done    = (state == ST_FINISH) && !abort;

  // Next-state selection; abort outranks stall and normal progress
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = dims_ok ? ST_RUN : ST_FINISH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!stall && last_pix) begin
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (will_empty) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State, latched dimensions and the raster/address counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      width_lat  <= '0;
      height_lat <= '0;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start && dims_ok) begin
        width_lat  <= cfg_width;
        height_lat <= cfg_height;
        x          <= '0;
        y          <= '0;
        addr       <= '0;
      end else if (state == ST_RUN && !stall && !abort) begin
        addr <= addr + ADDR_W'(1);
        if (row_end) begin
          x <= '0;
          y <= last_pix ? '0 : y + DIM_W'(1);
        end else begin
          x <= x + DIM_W'(1);
        end
      end
    end
  end

  sweep_delay_pipe #(
    .ADDR_W (ADDR_W),
    .LAT    (LAT)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .advance    (!stall),
    .flush      (abort && busy),
    .in_valid   (rd_en),
    .in_addr    (addr),
    .out_valid  (pipe_valid),
    .out_addr   (wr_addr),
    .will_empty (will_empty)
  );

`ifdef FRAME_SWEEP_PERF_EN
  logic [31:0] perf_cnt;

  // Busy-cycle counter, restarted by every accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt <= 32'd0;
    end else if (state == ST_IDLE && start) begin
      perf_cnt <= 32'd0;
    end else if (busy) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign cycle_count = perf_cnt;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_frame_sweep_controller.sv
// Self-checking bench for frame_sweep_controller: per-cycle expectations are
// derived from pixel issue/retire timing rules, with random stalls and aborts.
module tb_frame_sweep_controller;

  localparam int ADDR_W = 17;
  localparam int DIM_W  = 9;
  localparam int LAT    = 2;
  localparam int MAXC   = 220;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              stall;
  logic [DIM_W-1:0]  cfg_width;
  logic [DIM_W-1:0]  cfg_height;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DIM_W-1:0]  rd_x;
  logic [DIM_W-1:0]  rd_y;
  logic              wren;
  logic [ADDR_W-1:0] wr_addr;
  logic              done;
  logic [31:0]       cycle_count;

  int total = 0;
  int bad   = 0;

  bit stall_a [MAXC];
  bit e_rd    [MAXC];
  bit e_wr    [MAXC];
  int e_rpix  [MAXC];
  int e_wpix  [MAXC];
  int issue_c [64];

  frame_sweep_controller #(
    .ADDR_W   (ADDR_W),
    .DIM_W    (DIM_W),
    .PIPE_LAT (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .stall       (stall),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .busy        (busy),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .wren        (wren),
    .wr_addr     (wr_addr),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},    {31'd0, busy},     32'd0);
    check({tag, " rd_en"},   {31'd0, rd_en},    32'd0);
    check({tag, " wren"},    {31'd0, wren},     32'd0);
    check({tag, " done"},    {31'd0, done},     32'd0);
    check({tag, " rd_addr"}, {15'd0, rd_addr},  32'd0);
    check({tag, " rd_x"},    {23'd0, rd_x},     32'd0);
    check({tag, " rd_y"},    {23'd0, rd_y},     32'd0);
    check({tag, " wr_addr"}, {15'd0, wr_addr},  32'd0);
    check({tag, " cycles"},  cycle_count,       32'd0);
  endtask

  // One sweep started at edge 0. Stall window [s_lo,s_hi] plus s_pct% random
  // stalls; abort_at: 0 none, -1 random, >0 that cycle. noisy adds ignored
  // start pulses and cfg changes while busy.
  task automatic run_sweep(input int w, input int h, input int s_lo, input int s_hi,
                           input int s_pct, input int abort_at, input bit noisy);
    int n, p, cnt, last_w, done_c, busy_end, end_c, ab, exp_cc;
    n = w * h;
    for (int c = 0; c < MAXC; c++) begin
      stall_a[c] = (c >= s_lo && c <= s_hi) ||
                   (c > 0 && c < 120 && $urandom_range(99) < s_pct);
      e_rd[c] = 1'b0; e_wr[c] = 1'b0; e_rpix[c] = 0; e_wpix[c] = 0;
    end
    stall_a[0] = 1'b0;
    // a pixel is read in each non-stalled cycle, in raster order
    p = 0;
    for (int c = 1; c < MAXC && p < n; c++) begin
      if (!stall_a[c]) begin
        e_rd[c] = 1'b1; e_rpix[c] = p; issue_c[p] = c; p++;
      end
    end
    // its write happens in the LAT-th non-stalled cycle after the read
    last_w = 0;
    for (int q = 0; q < n; q++) begin
      cnt = 0;
      for (int k = issue_c[q] + 1; k < MAXC; k++) begin
        if (!stall_a[k]) begin
          cnt++;
          if (cnt == LAT) begin
            e_wr[k] = 1'b1; e_wpix[k] = q; last_w = k;
            break;
          end
        end
      end
    end
    done_c = (n == 0) ? 1 : last_w + 1;
    ab = abort_at;
    if (ab < 0) ab = (done_c > 1) ? $urandom_range(1, done_c - 1) : 0;
    busy_end = done_c;
    if (ab > 0) begin
      busy_end = ab;
      done_c = 0;
      for (int c = ab + 1; c < MAXC; c++) begin
        e_rd[c] = 1'b0; e_wr[c] = 1'b0;
      end
    end
    end_c = busy_end + 3;

    #1;
    cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
    start = 1'b1; abort = 1'b0; stall = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= end_c; c++) begin
      #1;
      start = noisy && c <= busy_end && ($urandom_range(3) == 0);
      if (noisy) begin
        cfg_width  = DIM_W'($urandom_range(0, 7));
        cfg_height = DIM_W'($urandom_range(0, 7));
      end
      stall = stall_a[c];
      abort = (c == ab);
      @(negedge clk);
      check($sformatf("busy c%0d", c),  {31'd0, busy},  {31'd0, c <= busy_end});
      check($sformatf("rd_en c%0d", c), {31'd0, rd_en}, {31'd0, e_rd[c]});
      if (e_rd[c]) begin
        check($sformatf("rd_addr c%0d", c), {15'd0, rd_addr}, e_rpix[c]);
        check($sformatf("rd_x c%0d", c),    {23'd0, rd_x},    e_rpix[c] % w);
        check($sformatf("rd_y c%0d", c),    {23'd0, rd_y},    e_rpix[c] / w);
      end
      check($sformatf("wren c%0d", c), {31'd0, wren}, {31'd0, e_wr[c]});
      if (e_wr[c]) begin
        check($sformatf("wr_addr c%0d", c), {15'd0, wr_addr}, e_wpix[c]);
      end
      check($sformatf("done c%0d", c), {31'd0, done}, {31'd0, c == done_c});
      @(posedge clk);
    end
    #1;
    start = 1'b0; abort = 1'b0; stall = 1'b0;
`ifdef FRAME_SWEEP_PERF_EN
    exp_cc = busy_end;
`else
    exp_cc = 0;
`endif
    check($sformatf("cycle_count %0dx%0d", w, h), cycle_count, exp_cc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    cfg_width = '0; cfg_height = '0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // basic sweep, stall window 5-7, abort at 6 followed by a full sweep
    run_sweep(4, 3, 0, -1, 0, 0, 1'b0);
    run_sweep(4, 3, 5, 7, 0, 0, 1'b0);
    run_sweep(4, 3, 0, -1, 0, 6, 1'b0);
    run_sweep(4, 3, 0, -1, 0, 0, 1'b0);

    // zero-sized images and degenerate single row/column
    run_sweep(0, 5, 0, -1, 0, 0, 1'b0);
    run_sweep(3, 0, 0, -1, 0, 0, 1'b0);
    run_sweep(1, 1, 0, -1, 0, 0, 1'b0);
    run_sweep(5, 1, 0, -1, 20, 0, 1'b1);

    // random sizes, stalls, busy start pulses and occasional aborts
    for (int i = 0; i < 10; i++) begin
      run_sweep($urandom_range(1, 6), $urandom_range(1, 5), 0, -1, 25,
                (i % 3 == 2) ? -1 : 0, 1'b1);
    end

    // async reset while draining: outputs clear before the next edge, no done
    #1;
    cfg_width = 9'd4; cfg_height = 9'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    check("drain busy",  {31'd0, busy},  32'd1);
    check("drain rd_en", {31'd0, rd_en}, 32'd0);
    reset = 1'b1;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("post reset done c%0d", c), {31'd0, done}, 32'd0);
      check($sformatf("post reset busy c%0d", c), {31'd0, busy}, 32'd0);
    end

    // controller must still run a full sweep after the reset
    run_sweep(4, 3, 0, -1, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sweep_controller.md
Name: frame_sweep_controller

Overview:
- Parametrised successor of the single-pass start/done controller.
- Sweeps a runtime-sized image pixel by pixel, issuing read addresses and coordinates to the processing datapath.
- Delays its own write-enable and write-address through a PIPE_LAT-deep tracking pipe, then reports completion.
- Sits between the host/command interface and the image-processing datapath/frame memory.

Parameters:
- ADDR_W, 17, width of read/write linear addresses.
- DIM_W, 9, width of cfg_width, cfg_height and the coordinate counters.
- PIPE_LAT, 2, datapath latency in cycles from rd_en to result valid; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level sampled in IDLE; begins a sweep.
- abort  in  1  terminates the sweep; no done pulse.
- stall  in  1  freezes issue and tracking pipe while high.
- cfg_width  in  DIM_W  image width in pixels; latched on accepted start.
- cfg_height  in  DIM_W  image height in pixels; latched on accepted start.
- busy  out  1  high in RUN, DRAIN and FINISH.
- rd_en  out  1  datapath enable; one pixel issued per cycle.
- rd_addr  out  ADDR_W  linear read address.
- rd_x  out  DIM_W  column of the issued pixel.
- rd_y  out  DIM_W  row of the issued pixel.
- wren  out  1  result write strobe, rd_en delayed by PIPE_LAT.
- wr_addr  out  ADDR_W  rd_addr delayed by PIPE_LAT.
- done  out  1  one-cycle completion pulse.
- cycle_count  out  32  busy-cycle counter (see Optional Feature).

Behaviour:
- Reset: state IDLE; every output 0; counters and pipe cleared. Reset is asynchronous and may arrive mid-sweep: the sweep is lost and no done pulse follows.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - start=1 with both dims nonzero -> latch dims, clear x/y/addr, go RUN.
  - start=1 with either dim 0 -> go FINISH (no reads, no writes).
  - start while busy is ignored.
- RUN, stall=0: rd_en=1 with the current rd_addr/rd_x/rd_y.
  - Each cycle: x++; on x==width-1, x=0 and y++.
  - rd_addr increments by 1 per pixel (running counter, no multiplier).
  - After issuing pixel (width-1, height-1) -> DRAIN.
- RUN, stall=1: rd_en=0; counters hold; tracking pipe holds. wren=0 throughout the stall; the pipe resumes unchanged when stall falls.
- Tracking pipe: PIPE_LAT-stage shift of {valid, addr}.
  - Advances only when stall=0.
  - wren is the last-stage valid and wr_addr the last-stage addr, both combinational from that stage.
- DRAIN: rd_en=0. Stay until all pipe stages are invalid, then go FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy falls in the same edge that leaves FINISH.
- abort (RUN/DRAIN/FINISH):
  - Next edge -> IDLE; pipe flushed.
  - No further wren; done is not asserted.
  - abort has priority over stall and over the normal transition.
- Timing, no stalls, start sampled at edge 0, N = width*height:
  - rd_en in cycles 1..N.
  - wren in cycles 1+PIPE_LAT..N+PIPE_LAT.
  - done in cycle N+PIPE_LAT+1.
- Arithmetic: width*height must not exceed 2^ADDR_W; overflow is the caller's responsibility. The address wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: FRAME_SWEEP_PERF_EN.
- Defined: cycle_count clears on accepted start and increments every busy cycle, including stall cycles. It holds its value after done/abort until the next start.
- Undefined: cycle_count is tied to 0 and no counter logic is built.

Decomposition:
- Shared package frame_pkg: state enum (IDLE/RUN/DRAIN/FINISH), DIM_W/ADDR_W defaults, PIPE_LAT limits.
- One sub-module: sweep_delay_pipe, the parametrised {valid, addr} shift register with advance enable and synchronous flush.

Test Plan:
- Basic sweep: width=4, height=3, PIPE_LAT=2, start at edge 0 -> rd_en cycles 1-12 with addr 0..11 and (x,y) ending at (3,2); wren cycles 3-14 with wr_addr 0..11; done=1 only in cycle 15; busy 1..15.
- Stall: same config, stall high during cycles 5-7 -> rd_addr 4 held, no rd_en/wren in 5-7; done in cycle 18; no address skipped or duplicated.
- Abort: abort during cycle 6 of the basic sweep -> IDLE at cycle 7; no wren from cycle 7 on; done never asserted; a new start then runs a full sweep.
- Zero size: width=0, height=5, start -> no rd_en/wren; done one cycle after the start is accepted.
- Busy start and async reset: start pulses mid-sweep are ignored; reset asserted mid-DRAIN -> all outputs 0 immediately (before the next edge); no done.
- With FRAME_SWEEP_PERF_EN defined: basic sweep gives cycle_count=15 after done; the stall scenario gives 18.
